// File: rtl/jacobi_pkg.sv
// Shared state encoding, default widths and timeout constant for the Jacobi sequencer.
package jacobi_pkg;

    localparam int IDX_W_DEF   = 10;
    localparam int YA_W_DEF    = 20;
    localparam int TIMEOUT_CYC = 255;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACC = 3'd2,
        WRITE    = 3'd3,
        ITER_END = 3'd4,
        FINISH   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/seq_addr_gen.sv
// Row/column counters and Y SRAM address for the Jacobi sequencer.
// The row base advances by n_dim per row, so y_addr = row*n_dim + col needs no multiplier.
module seq_addr_gen
    import jacobi_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int YA_W  = YA_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             col_step,
    input  logic             row_step,
    input  logic [IDX_W-1:0] n_dim,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic [YA_W-1:0]  y_addr,
    output logic             last_col,
    output logic             last_row
);

    logic [YA_W-1:0]  base;
    logic [IDX_W-1:0] n_last;

    assign n_last   = n_dim - IDX_W'(1);
    assign last_col = (col == n_last);
    assign last_row = (row == n_last);
    assign y_addr   = base + YA_W'(col);

    always_ff @(posedge clock) begin
        if (!reset) begin
            row  <= '0;
            col  <= '0;
            base <= '0;
        end else if (clear) begin
            row  <= '0;
            col  <= '0;
            base <= '0;
        end else begin
            if (col_step) begin
                col <= last_col ? '0 : col + IDX_W'(1);
            end
            if (row_step) begin
                row  <= row + IDX_W'(1);
                base <= base + YA_W'(n_dim);
            end
        end
    end

endmodule

// File: rtl/jacobi_iter_sequencer.sv
// Jacobi iteration sequencer: walks the matrix row by row, feeds the accumulator, writes back V.
// Optional accumulator watchdog enabled by defining JACOBI_SEQ_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | waiting for start
//   ISSUE    | one Y/V pair per cycle for the current row
//   WAIT_ACC | waiting for the accumulator row result
//   WRITE    | write updated V element for the row
//   ITER_END | count iteration, decide stop or sweep again
//   FINISH   | one-cycle done pulse
module jacobi_iter_sequencer
    import jacobi_pkg::*;
#(
    parameter int N_MAX = 256,
    parameter int IDX_W = IDX_W_DEF,
    parameter int YA_W  = YA_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] n_dim,
    input  logic [7:0]       max_iter,
    input  logic             converged,
    input  logic             accum_done,
    output logic [YA_W-1:0]  y_addr,
    output logic [IDX_W-1:0] v_rd_addr,
    output logic             mac_valid,
    output logic             mac_last,
    output logic             v_wr_en,
    output logic [IDX_W-1:0] v_wr_addr,
    output logic [7:0]       iter_count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    seq_state_t       state, state_next;
    logic [IDX_W-1:0] n_lat, n_req, row, col;
    logic [YA_W-1:0]  y_gen;
    logic [7:0]       max_lat, iter_next;
    logic             last_col, last_row;
    logic             start_ok, iter_stop, tmo_hit;
    logic             gen_clear, gen_col_step, gen_row_step;

    // Dimensions beyond the supported size are clamped rather than overrunning the SRAMs.
    assign n_req     = (n_dim > IDX_W'(N_MAX)) ? IDX_W'(N_MAX) : n_dim;
    assign start_ok  = (state == IDLE) && start;
    assign iter_next = iter_count + 8'd1;
    assign iter_stop = converged || (iter_next == max_lat);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (n_req == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (last_col) begin
                    state_next = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                if (accum_done) begin
                    state_next = WRITE;
                end else if (tmo_hit) begin
                    state_next = FINISH;
                end
            end
            WRITE:    state_next = last_row ? ITER_END : ISSUE;
            ITER_END: state_next = iter_stop ? FINISH : ISSUE;
            FINISH:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        mac_valid    = 1'b0;
        mac_last     = 1'b0;
        y_addr       = '0;
        v_rd_addr    = '0;
        v_wr_en      = 1'b0;
        v_wr_addr    = '0;
        done         = 1'b0;
        gen_clear    = start_ok;
        gen_col_step = 1'b0;
        gen_row_step = 1'b0;
        case (state)
            ISSUE: begin
                mac_valid    = 1'b1;
                mac_last     = last_col;
                y_addr       = y_gen;
                v_rd_addr    = col;
                gen_col_step = 1'b1;
            end
            WRITE: begin
                v_wr_en      = 1'b1;
                v_wr_addr    = row;
                gen_row_step = !last_row;
            end
            ITER_END: gen_clear = 1'b1;
            FINISH:   done      = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            n_lat      <= '0;
            max_lat    <= '0;
            iter_count <= '0;
        end else if (start_ok) begin
            n_lat      <= n_req;
            max_lat    <= (max_iter == 8'd0) ? 8'd1 : max_iter;
            iter_count <= '0;
        end else if (state == ITER_END) begin
            iter_count <= iter_next;
        end
    end

`ifdef JACOBI_SEQ_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    // Down-counter reloaded outside WAIT_ACC; terminal count marks the last allowed wait cycle.
    assign tmo_hit = (state == WAIT_ACC) && !accum_done && (tmo_cnt == 8'd0);
    assign error   = err_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state != WAIT_ACC) begin
                tmo_cnt <= 8'(TIMEOUT_CYC - 1);
            end else if (!accum_done && tmo_cnt != 8'd0) begin
                tmo_cnt <= tmo_cnt - 8'd1;
            end
            if (start_ok) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign error   = 1'b0;
`endif

    seq_addr_gen #(
        .IDX_W (IDX_W),
        .YA_W  (YA_W)
    ) u_addr_gen (
        .clock    (clock),
        .reset    (reset),
        .clear    (gen_clear),
        .col_step (gen_col_step),
        .row_step (gen_row_step),
        .n_dim    (n_lat),
        .row      (row),
        .col      (col),
        .y_addr   (y_gen),
        .last_col (last_col),
        .last_row (last_row)
    );

endmodule

// File: tb/tb_jacobi_iter_sequencer.sv
// Directed scoreboard bench for jacobi_iter_sequencer (both JACOBI_SEQ_TIMEOUT_EN builds).
module tb_jacobi_iter_sequencer;

    localparam int IDX_W   = 10;
    localparam int YA_W    = 20;
    localparam int ACC_LAT = 2;

    typedef struct packed {
        logic [YA_W-1:0]  y;
        logic [IDX_W-1:0] c;
        logic             last;
    } iss_t;

    logic             clock = 1'b0;
    logic             reset, start, converged, accum_done;
    logic [IDX_W-1:0] n_dim;
    logic [7:0]       max_iter;
    logic [YA_W-1:0]  y_addr;
    logic [IDX_W-1:0] v_rd_addr, v_wr_addr;
    logic             mac_valid, mac_last, v_wr_en, busy, done, error;
    logic [7:0]       iter_count;

    iss_t             iss_q[$];
    logic [IDX_W-1:0] wr_q[$];

    int compared = 0, mismatched = 0;
    int n_issue, n_wr, n_done, lastrow_cnt, conv_after, cur_n, acc_wait;
    int tick_no = 0, last_ml_tick = 0;
    bit acc_en = 1'b1, noise_en = 1'b0;

    always #5 clock = ~clock;

    jacobi_iter_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .n_dim      (n_dim),
        .max_iter   (max_iter),
        .converged  (converged),
        .accum_done (accum_done),
        .y_addr     (y_addr),
        .v_rd_addr  (v_rd_addr),
        .mac_valid  (mac_valid),
        .mac_last   (mac_last),
        .v_wr_en    (v_wr_en),
        .v_wr_addr  (v_wr_addr),
        .iter_count (iter_count),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, score outputs, then drive responder inputs.
    task automatic tick();
        iss_t e;
        @(negedge clock);
        tick_no++;
        if (mac_valid) begin
            n_issue++;
            if (iss_q.size() > 0) begin
                e = iss_q.pop_front();
                check("y_addr", 64'(y_addr), 64'(e.y));
                check("v_rd_addr", 64'(v_rd_addr), 64'(e.c));
                check("mac_last", 64'(mac_last), 64'(e.last));
            end
            if (mac_last) last_ml_tick = tick_no;
        end
        if (v_wr_en) begin
            n_wr++;
            if (wr_q.size() > 0) check("v_wr_addr", 64'(v_wr_addr), 64'(wr_q.pop_front()));
            if (v_wr_addr == IDX_W'(cur_n - 1)) lastrow_cnt++;
        end
        if (done) n_done++;
        accum_done = 1'b0;
        if (acc_wait > 0) begin
            acc_wait--;
            if (acc_wait == 0) accum_done = 1'b1;
        end
        if (acc_en && mac_valid && mac_last) acc_wait = ACC_LAT;
        if (noise_en && mac_valid && !mac_last) accum_done = 1'b1;
        if (noise_en) start = busy;
        converged = (conv_after != 0) && (lastrow_cnt >= conv_after);
    endtask

    task automatic prep(input int n, input int iters, input int conv, input bit noise);
        iss_t e;
        n_issue = 0; n_wr = 0; n_done = 0; lastrow_cnt = 0;
        conv_after = conv; cur_n = n; noise_en = noise;
        iss_q.delete(); wr_q.delete();
        for (int it = 0; it < iters; it++) begin
            for (int r = 0; r < n; r++) begin
                for (int c = 0; c < n; c++) begin
                    e.y = YA_W'(r * n + c);
                    e.c = IDX_W'(c);
                    e.last = (c == n - 1);
                    iss_q.push_back(e);
                end
                wr_q.push_back(IDX_W'(r));
            end
        end
    endtask

    task automatic pulse_start(input int n, input int mx);
        n_dim = IDX_W'(n); max_iter = 8'(mx); start = 1'b1;
        tick();
        start = 1'b0; n_dim = 10'd7; max_iter = 8'd0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int used = 0;
        while (n_done == 0 && used < budget) begin
            tick();
            used++;
        end
        check({tag, "_done_seen"}, 64'(n_done > 0), 64'd1);
    endtask

    task automatic run_solve(input string tag, input int n, input int mx, input int iters,
                             input int conv, input bit noise);
        prep(n, iters, conv, noise);
        pulse_start(n, mx);
        wait_done(tag, 4000);
        for (int k = 0; k < 3; k++) tick();
        noise_en = 1'b0; start = 1'b0; conv_after = 0; converged = 1'b0;
        check({tag, "_iter_count"}, 64'(iter_count), 64'(iters));
        check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
        check({tag, "_writes"}, 64'(n_wr), 64'(n * iters));
        check({tag, "_issues"}, 64'(n_issue), 64'(n * n * iters));
        check({tag, "_iss_q_left"}, 64'(iss_q.size()), 64'd0);
        check({tag, "_wr_q_left"}, 64'(wr_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({y_addr, v_rd_addr, mac_valid, mac_last, v_wr_en, v_wr_addr,
                    iter_count, busy, done, error});
    endfunction

    initial begin
        bit found;
        reset = 1'b0; start = 1'b0; converged = 1'b0; accum_done = 1'b0;
        n_dim = '0; max_iter = '0; acc_wait = 0; cur_n = 0; conv_after = 0;
        n_issue = 0; n_wr = 0; n_done = 0; lastrow_cnt = 0;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        check("reset_outputs", all_outputs(), 64'd0);

        run_solve("n3_it1", 3, 1, 1, 0, 1'b0);
        run_solve("n4_conv2", 4, 10, 2, 2, 1'b0);

        prep(0, 0, 0, 1'b0);
        pulse_start(0, 5);
        wait_done("n0", 2);
        for (int k = 0; k < 3; k++) tick();
        check("n0_issues", 64'(n_issue), 64'd0);
        check("n0_iter_count", 64'(iter_count), 64'd0);
        check("n0_done_pulses", 64'(n_done), 64'd1);

        run_solve("maxit0", 2, 0, 1, 0, 1'b0);
        run_solve("n1_it3", 1, 3, 3, 0, 1'b0);
        run_solve("noise", 3, 2, 2, 0, 1'b1);

        // Reset while row 1 is being issued.
        prep(4, 1, 0, 1'b0);
        pulse_start(4, 1);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (mac_valid && y_addr == YA_W'(4)) found = 1'b1;
        end
        check("rst_row1_reached", 64'(found), 64'd1);
        reset = 1'b0;
        tick();
        check("rst_mid_outputs", all_outputs(), 64'd0);
        reset = 1'b1; acc_wait = 0; accum_done = 1'b0;
        run_solve("after_rst", 2, 1, 1, 0, 1'b0);

        // Accumulator never answers.
        prep(2, 1, 0, 1'b0);
        acc_en = 1'b0;
        pulse_start(2, 1);
`ifdef JACOBI_SEQ_TIMEOUT_EN
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            if (error) found = 1'b1;
        end
        check("tmo_error_seen", 64'(found), 64'd1);
        check("tmo_latency", 64'(tick_no - last_ml_tick), 64'd256);
        check("tmo_done", 64'(n_done), 64'd1);
        tick(); tick();
        check("tmo_error_sticky", 64'(error), 64'd1);
        check("tmo_idle", 64'(busy), 64'd0);
        acc_en = 1'b1;
        prep(0, 0, 0, 1'b0);
        pulse_start(0, 1);
        check("tmo_error_cleared", 64'(error), 64'd0);
        tick(); tick();
`else
        for (int k = 0; k < 300; k++) tick();
        check("no_tmo_busy", 64'(busy), 64'd1);
        check("no_tmo_error", 64'(error), 64'd0);
        check("no_tmo_done", 64'(n_done), 64'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1; acc_en = 1'b1; acc_wait = 0;
        check("no_tmo_reset_idle", 64'(busy), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jacobi_iter_sequencer.md
JACOBI_ITER_SEQUENCER -- requirements
Module: jacobi_iter_sequencer

Interface
REQ-001 SHALL have parameter N_MAX, default 256: largest supported matrix dimension.
REQ-002 SHALL have parameter IDX_W, default 10: row/column index width.
REQ-003 SHALL have parameter YA_W, default 20: Y SRAM address width.
REQ-004 SHALL have port clock  in  1: rising-edge clock.
REQ-005 SHALL have port reset  in  1: reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1: one-cycle solve request, sampled only in IDLE.
REQ-007 SHALL have port n_dim  in  IDX_W: active dimension, latched at start.
REQ-008 SHALL have port max_iter  in  8: iteration limit, latched at start.
REQ-009 SHALL have port converged  in  1: delta-checker verdict, sampled only in ITER_END.
REQ-010 SHALL have port accum_done  in  1: accumulator row result valid.
REQ-011 SHALL have port y_addr  out  YA_W: Y SRAM read address.
REQ-012 SHALL have port v_rd_addr  out  IDX_W: V SRAM read address (column).
REQ-013 SHALL have port mac_valid  out  1: Y/V pair issued to accumulator this cycle.
REQ-014 SHALL have port mac_last  out  1: final column of current row.
REQ-015 SHALL have port v_wr_en  out  1: write updated V element.
REQ-016 SHALL have port v_wr_addr  out  IDX_W: row being written.
REQ-017 SHALL have port iter_count  out  8: completed iterations.
REQ-018 SHALL have port busy  out  1: high in every state except IDLE.
REQ-019 SHALL have port done  out  1: one-cycle completion pulse.
REQ-020 SHALL have port error  out  1: accumulator timeout flag.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT_ACC, WRITE, ITER_END, FINISH.
REQ-022 IDLE: start=1 with n_dim!=0 -> ISSUE, row=col=0, iter_count=0; n_dim=0 -> FINISH, no SRAM access.
REQ-023 ISSUE: one column per cycle; mac_valid=1; y_addr=row*n_dim+col; v_rd_addr=col; mac_last=1 when col==n_dim-1; then -> WAIT_ACC.
REQ-024 y_addr SHALL be formed incrementally (row base += n_dim per row), no multiplier.
REQ-025 WAIT_ACC: hold until accum_done=1 (any latency), then -> WRITE.
REQ-026 WRITE: exactly one cycle; v_wr_en=1, v_wr_addr=row; last row -> ITER_END, else row+1 -> ISSUE.
REQ-027 ITER_END: iter_count+1; converged=1 or new iter_count==max_iter -> FINISH; else row=0 -> ISSUE.
REQ-028 max_iter=0 SHALL be treated as 1.
REQ-029 FINISH: done=1 one cycle, -> IDLE; iter_count SHALL hold until next accepted start.
REQ-030 start outside IDLE and accum_done outside WAIT_ACC SHALL be ignored.
REQ-031 mac_valid, mac_last, v_wr_en, done SHALL be 0 outside their stated states.

Reset
REQ-032 reset=0 at a clock edge SHALL force IDLE from any state, including mid-row.
REQ-033 After reset all outputs, row, col, base, iter_count SHALL be 0.

Configuration
REQ-034 With JACOBI_SEQ_TIMEOUT_EN defined, a counter SHALL run in WAIT_ACC; 255 cycles without accum_done -> error=1 (sticky until next start) and -> FINISH.
REQ-035 Without JACOBI_SEQ_TIMEOUT_EN, error SHALL be tied 0 and WAIT_ACC SHALL wait indefinitely.

Structure
REQ-036 Package jacobi_pkg SHALL hold the state enum, IDX_W/YA_W defaults and the TIMEOUT_CYC=255 constant.
REQ-037 Sub-module seq_addr_gen SHALL own the row/col counters and incremental y_addr base.

Verification
REQ-038 n_dim=3, max_iter=1, accum_done 2 cycles after mac_last -> y_addr 0..8 in row order, v_wr_addr 0,1,2, iter_count=1, one done pulse.
REQ-039 n_dim=4, max_iter=10, converged=1 in the 2nd ITER_END -> iter_count=2, done, exactly 8 v_wr_en pulses.
REQ-040 n_dim=0 with start -> done 2 cycles later, mac_valid never high, iter_count=0.
REQ-041 reset=0 during row 1 ISSUE of n_dim=4 -> next cycle IDLE, all outputs 0; later start restarts at y_addr=0.
REQ-042 Timeout enabled, accum_done withheld -> error=1 at WAIT_ACC cycle 255, done pulse; disabled -> busy stays 1.
REQ-043 start pulsed while busy and accum_done pulsed during ISSUE -> no effect on the address sequence or write count.
